// File: rtl/card_stream_pkg.sv
// Shared constants and helpers for the card stream merger.
package card_stream_pkg;

   localparam int unsigned CARD_MAX_CH = 32;

   // Channel-tag width; a single channel still needs one tag bit.
   function automatic int unsigned CARD_ID_W(input int unsigned num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/card_stream_fifo.sv
// Synchronous FIFO whose head entry and valid flag are held in dedicated output registers.
module card_stream_fifo #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             push,
   input  logic [DATA_W-1:0]                push_data,
   input  logic                             push_last,
   input  logic                             pop,
   output logic                             out_valid,
   output logic [DATA_W-1:0]                out_data,
   output logic                             out_last,
   output logic [$clog2(DEPTH + 1)-1:0]     count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head_q, head_d, wr_entry;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          valid_q, do_push, do_pop;

   always_comb begin
      wr_entry = '{data: push_data, last: push_last};
      do_push  = push && (count_q != CW'(DEPTH));
      do_pop   = pop && valid_q;
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      head_d   = head_q;
      // The new head may be the slot being written this very cycle.
      if (count_d != '0) begin
         head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wr_entry : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         head_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         head_q   <= head_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= (count_d != '0);
      end
   end

   assign out_valid = valid_q;
   assign out_data  = head_q.data;
   assign out_last  = head_q.last;
   assign count     = count_q;

endmodule

// File: rtl/card_stream_merger.sv
// Round-robin N-to-1 AXI-Stream merger with source-channel tagging and a registered output FIFO.
// Packet locking on s_tlast is enabled by defining CARD_MERGE_PKT_LOCK_EN.
module card_stream_merger
   import card_stream_pkg::*;
#(
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned DATA_W    = 64,
   parameter int unsigned OUT_DEPTH = 2
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUM_CH*DATA_W-1:0] s_tdata,
   input  logic [NUM_CH-1:0]        s_tvalid,
   output logic [NUM_CH-1:0]        s_tready,
   output logic [DATA_W-1:0]        m_tdata,
   output logic                     m_tvalid,
   input  logic                     m_tready
`ifdef CARD_MERGE_PKT_LOCK_EN
   ,
   input  logic [NUM_CH-1:0]        s_tlast,
   output logic                     m_tlast
`endif
);
   localparam int unsigned ID_W = CARD_ID_W(NUM_CH);
   localparam int unsigned CW   = $clog2(OUT_DEPTH + 1);

   // Rotate requests by ptr, take the lowest set bit, rotate the index back.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [ID_W-1:0]   ptr);
      logic [2*NUM_CH-1:0] dbl;
      logic [ID_W:0]       res;
      int                  idx;
      dbl = {req, req} >> ptr;
      res = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (dbl[i]) begin
            idx = (int'(ptr) + i) % int'(NUM_CH);
            res = {1'b1, ID_W'(idx)};
         end
      end
      return res;
   endfunction

   logic [ID_W-1:0]   rr_q, rr_d, grant;
   logic              grant_valid, full, accept, beat_last, push_last, pop;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] push_data;

`ifdef CARD_MERGE_PKT_LOCK_EN
   logic            lock_q;
   logic [ID_W-1:0] lock_ch_q;
`else
   logic            unused_last;
`endif

   always_comb begin
      {grant_valid, grant} = rr_pick(s_tvalid, rr_q);
`ifdef CARD_MERGE_PKT_LOCK_EN
      if (lock_q) begin
         grant       = lock_ch_q;
         grant_valid = s_tvalid[lock_ch_q];
      end
      beat_last = s_tlast[grant];
      push_last = beat_last;
`else
      beat_last = 1'b1;
      push_last = 1'b0;
`endif
      full     = (count == CW'(OUT_DEPTH));
      s_tready = '0;
      // Gated by reset so ready drops asynchronously with aresetn.
      s_tready[grant] = grant_valid & ~full & aresetn;
      accept   = s_tready[grant] & s_tvalid[grant];
      push_data = s_tdata[grant*DATA_W +: DATA_W];
      push_data[ID_W-1:0] = grant;
      rr_d = rr_q;
      if (accept && beat_last) begin
         rr_d = (int'(grant) == int'(NUM_CH) - 1) ? '0 : grant + ID_W'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rr_q <= '0;
      else          rr_q <= rr_d;
   end

`ifdef CARD_MERGE_PKT_LOCK_EN
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lock_q    <= 1'b0;
         lock_ch_q <= '0;
      end else if (accept) begin
         lock_q    <= ~beat_last;
         lock_ch_q <= grant;
      end
   end
`endif

   assign pop = m_tvalid & m_tready;

   card_stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (OUT_DEPTH)
   ) u_fifo (
      .clk       (aclk),
      .rst_n     (aresetn),
      .push      (accept),
      .push_data (push_data),
      .push_last (push_last),
      .pop       (pop),
      .out_valid (m_tvalid),
      .out_data  (m_tdata),
`ifdef CARD_MERGE_PKT_LOCK_EN
      .out_last  (m_tlast),
`else
      .out_last  (unused_last),
`endif
      .count     (count)
   );

endmodule

// File: tb/tb_card_stream_merger.sv
// Scoreboard bench for card_stream_merger: randomized and directed traffic against a queue-based model.
`timescale 1ns/1ps
module tb_card_stream_merger;
   localparam int NCH   = 8;
   localparam int DW    = 64;
   localparam int DEPTH = 2;
   localparam int IDW   = 3;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic [NCH*DW-1:0] s_tdata = '0;
   logic [NCH-1:0]    s_tvalid = '0;
   logic [NCH-1:0]    s_tready;
   logic [DW-1:0]     m_tdata;
   logic              m_tvalid;
   logic              m_tready = 1'b0;
`ifdef CARD_MERGE_PKT_LOCK_EN
   logic [NCH-1:0]    s_tlast = '1;
   logic              m_tlast;
`endif

   card_stream_merger #(.NUM_CH(NCH), .DATA_W(DW), .OUT_DEPTH(DEPTH)) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .s_tdata  (s_tdata),
      .s_tvalid (s_tvalid),
      .s_tready (s_tready),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
`ifdef CARD_MERGE_PKT_LOCK_EN
      .m_tready (m_tready),
      .s_tlast  (s_tlast),
      .m_tlast  (m_tlast)
`else
      .m_tready (m_tready)
`endif
   );

   always #5 aclk = ~aclk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   beat_t exp_q[$];
   int    dut_grants[$];
   int    rr = 0;
   int    occ = 0;
   bit    locked = 0;
   int    lock_ch = 0;

   // Reference model: arbitration from the rr rule, occupancy as a plain counter.
   always @(negedge aclk) begin
      if (!aresetn) begin
         exp_q.delete();
         rr = 0; occ = 0; locked = 0; lock_ch = 0;
      end else begin
         int             g;
         bit             gv, lst;
         logic [NCH-1:0] exp_rdy;
         beat_t          b;
         g = 0; gv = 0;
         if (locked) begin
            g  = lock_ch;
            gv = s_tvalid[g];
         end else begin
            for (int k = 0; k < NCH; k++) begin
               if (!gv && s_tvalid[(rr + k) % NCH]) begin
                  g  = (rr + k) % NCH;
                  gv = 1;
               end
            end
         end
         exp_rdy = '0;
         if (gv && occ < DEPTH) exp_rdy[g] = 1'b1;
         check("s_tready", 64'(s_tready), 64'(exp_rdy));
         check("m_tvalid", 64'(m_tvalid), 64'(occ != 0));
         if (occ != 0 && m_tready) occ--;
         if (exp_rdy[g]) begin
            b.data = s_tdata[g*DW +: DW];
            b.data[IDW-1:0] = g[IDW-1:0];
`ifdef CARD_MERGE_PKT_LOCK_EN
            lst = s_tlast[g];
            b.last = lst;
            locked  = !lst;
            lock_ch = g;
`else
            lst = 1;
            b.last = 1'b0;
`endif
            exp_q.push_back(b);
            occ++;
            if (lst) rr = (g + 1) % NCH;
         end
      end
   end

   // Monitor: pop and compare on every output handshake; check AXI hold under backpressure.
   logic [DW-1:0] hold_data;
   bit            hold_pending = 0;
   always @(negedge aclk) begin
      if (!aresetn) begin
         hold_pending = 0;
      end else begin
         if (hold_pending) begin
            check("m_tvalid_hold", 64'(m_tvalid), 64'(1));
            check("m_tdata_stable", m_tdata, hold_data);
         end
         hold_pending = m_tvalid && !m_tready;
         hold_data    = m_tdata;
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat: got %h, want no beat at %0t", m_tdata, $time);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               check("m_tdata", m_tdata, b.data);
`ifdef CARD_MERGE_PKT_LOCK_EN
               check("m_tlast", 64'(m_tlast), 64'(b.last));
`endif
            end
         end
      end
   end

   // Observed DUT grants, for directed order checks.
   always @(negedge aclk) begin
      if (aresetn) begin
         for (int i = 0; i < NCH; i++) begin
            if (s_tready[i] && s_tvalid[i]) dut_grants.push_back(i);
         end
      end
   end

   task automatic next_cycle();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_ch(input int ch, input logic [DW-1:0] d);
      s_tdata[ch*DW +: DW] = d;
   endtask

   task automatic idle_drain(input int n);
      s_tvalid = '0;
      m_tready = 1'b1;
      repeat (n) next_cycle();
   endtask

   initial begin
      int base;
      logic [DW-1:0] pat;

      #1;
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_m_tdata", m_tdata, 64'(0));
      check("rst_s_tready", 64'(s_tready), 64'(0));
      next_cycle();
      aresetn = 1'b1;

      // All channels valid: strict rotation 0..7 twice at one beat per cycle.
      for (int i = 0; i < NCH; i++) set_ch(i, {32'hC0DE_0000, 32'(i * 16)});
      m_tready = 1'b1;
      base = dut_grants.size();
      s_tvalid = '1;
      repeat (16) next_cycle();
      s_tvalid = '0;
      check("rr_count", 64'(dut_grants.size() - base), 64'(16));
      for (int i = 0; i < 16 && base + i < dut_grants.size(); i++) begin
         check("rr_order", 64'(dut_grants[base + i]), 64'(i % NCH));
      end
      idle_drain(4);

      // Single channel 3: tag replaces the low bits of each beat.
      base = dut_grants.size();
      pat = 64'h1234_5678_9ABC_AB00;
      set_ch(3, pat);
      s_tvalid = 8'b0000_1000;
      next_cycle();
      pat = 64'h1234_5678_9ABC_AB01;
      set_ch(3, pat);
      next_cycle();
      s_tvalid = '0;
      check("ch3_beats", 64'(dut_grants.size() - base), 64'(2));
      idle_drain(4);

      // Backpressure: ch0 and ch5 valid with m_tready low; FIFO fills at two entries.
      base = dut_grants.size();
      m_tready = 1'b0;
      set_ch(0, 64'hAAAA_0000_0000_0F00);
      set_ch(5, 64'h5555_0000_0000_0F00);
      s_tvalid = 8'b0010_0001;
      repeat (5) next_cycle();
      check("bp_accepts", 64'(dut_grants.size() - base), 64'(DEPTH));
      check("bp_ready_zero", 64'(s_tready), 64'(0));
      idle_drain(6);

      // Wrap: park rr at 7 via ch6, then ch7 and ch0 compete.
      s_tvalid = 8'b0100_0000;
      next_cycle();
      base = dut_grants.size();
      s_tvalid = 8'b1000_0001;
      next_cycle();
      s_tvalid = 8'b0000_0001;
      next_cycle();
      s_tvalid = '0;
      check("wrap_count", 64'(dut_grants.size() - base), 64'(2));
      if (dut_grants.size() >= base + 2) begin
         check("wrap_first", 64'(dut_grants[base]), 64'(7));
         check("wrap_second", 64'(dut_grants[base + 1]), 64'(0));
      end
      idle_drain(4);

`ifdef CARD_MERGE_PKT_LOCK_EN
      // Three-beat packet on ch2 holds off ch1 until its last beat.
      base = dut_grants.size();
      s_tlast = '1;
      s_tlast[2] = 1'b0;
      s_tvalid = 8'b0000_0100;
      next_cycle();
      s_tvalid = 8'b0000_0110;
      next_cycle();
      s_tlast[2] = 1'b1;
      next_cycle();
      s_tvalid = 8'b0000_0010;
      next_cycle();
      s_tvalid = '0;
      check("lock_count", 64'(dut_grants.size() - base), 64'(4));
      for (int i = 0; i < 4 && base + i < dut_grants.size(); i++) begin
         check("lock_order", 64'(dut_grants[base + i]), 64'((i < 3) ? 2 : 1));
      end
      idle_drain(4);
`endif

      // Randomized traffic with random backpressure.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NCH; i++) set_ch(i, {$urandom, $urandom});
         s_tvalid = 8'($urandom);
         m_tready = ($urandom_range(0, 3) != 0);
`ifdef CARD_MERGE_PKT_LOCK_EN
         s_tlast = 8'($urandom);
`endif
         next_cycle();
      end
`ifdef CARD_MERGE_PKT_LOCK_EN
      s_tlast = '1;
`endif

      // Reset mid-stream with the FIFO full.
      m_tready = 1'b0;
      s_tvalid = '1;
      repeat (4) next_cycle();
      aresetn = 1'b0;
      #1;
      check("midrst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("midrst_s_tready", 64'(s_tready), 64'(0));
      check("midrst_m_tdata", m_tdata, 64'(0));
      next_cycle();
      aresetn = 1'b1;
      s_tvalid = 8'b0000_0010;
      set_ch(1, 64'hFEED_FACE_0000_1111);
      next_cycle();
      s_tvalid = '0;
      #3;
      check("post_rst_latency", 64'(m_tvalid), 64'(1));
      idle_drain(8);
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
